// File: rtl/par_frame_if.sv
// Receive-side frame stream and result bus for par_frame_checker.
// The master drives beats and clr_cnt; the slave returns the registered check results.
interface par_frame_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              mode;
    logic              in_valid;
    logic              in_sop;
    logic              in_eop;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              clr_cnt;
    logic              res_valid;
    logic              parity_ok;
    logic              frame_err;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output mode, in_valid, in_sop, in_eop, in_data, in_par, clr_cnt,
        input  res_valid, parity_ok, frame_err, err_cnt
    );

    modport slave (
        input  mode, in_valid, in_sop, in_eop, in_data, in_par, clr_cnt,
        output res_valid, parity_ok, frame_err, err_cnt
    );
endinterface

// File: rtl/par_frame_checker.sv
// Multi-beat framed parity checker: accumulates parity over sop..eop beats, checks it
// against the transmitted bit in even/odd mode, flags framing errors, counts failures.
module par_frame_checker #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    par_frame_if.slave bus
);
    localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic               acc_q,       acc_d;
    logic [BEAT_W-1:0]  beats_q,     beats_d;
    logic               mode_q,      mode_d;
    logic               res_valid_q, res_valid_d;
    logic               parity_ok_q, parity_ok_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;

    logic [DATA_W-1:0]  beat_data;
    logic               beat_par;
    logic               take;
    logic               acc_new;
    logic [BEAT_W-1:0]  beats_new;
    logic               mode_new;
    logic               cnt_inc;

    assign beat_data = bus.in_data;
    assign beat_par  = ^beat_data;

    // Next-state, frame bookkeeping and result generation
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        mode_d      = mode_q;
        res_valid_d = 1'b0;
        parity_ok_d = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        take        = 1'b0;
        acc_new     = acc_q;
        beats_new   = beats_q;
        mode_new    = mode_q;
        cnt_inc     = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_sop) begin
                // A sop while a frame is open aborts that frame silently apart from frame_err
                frame_err_d = (state_q == ACCUM);
                take        = 1'b1;
                acc_new     = beat_par;
                beats_new   = BEAT_W'(1);
                mode_new    = bus.mode;
            end else if (state_q == ACCUM) begin
                take        = 1'b1;
                acc_new     = acc_q ^ beat_par;
                beats_new   = beats_q + BEAT_W'(1);
            end else begin
                frame_err_d = 1'b1;
            end
        end

        if (take) begin
            if (bus.in_eop) begin
                res_valid_d = 1'b1;
                parity_ok_d = ((acc_new ^ bus.in_par) == mode_new);
                state_d     = IDLE;
                acc_d       = 1'b0;
                beats_d     = '0;
                mode_d      = mode_new;
            end else if (beats_new == BEAT_W'(MAX_BEATS)) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                acc_d       = 1'b0;
                beats_d     = '0;
                mode_d      = mode_new;
            end else begin
                state_d     = ACCUM;
                acc_d       = acc_new;
                beats_d     = beats_new;
                mode_d      = mode_new;
            end
        end

        // One saturating increment per cycle; clear has priority
        cnt_inc = frame_err_d | (res_valid_d & ~parity_ok_d);
        if (bus.clr_cnt) begin
            err_cnt_d = '0;
        end else if (cnt_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            beats_q     <= '0;
            mode_q      <= 1'b0;
            res_valid_q <= 1'b0;
            parity_ok_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            mode_q      <= mode_d;
            res_valid_q <= res_valid_d;
            parity_ok_q <= parity_ok_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.parity_ok = parity_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_par_frame_checker.sv
// Scoreboard bench for par_frame_checker: directed cases then random frames checked
// against a frame-list reference model.
module tb_par_frame_checker;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned CNT_W     = 2;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             rv;
        logic             ok;
        logic             fe;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exp_t              exp_q[$];
    bit                m_open;
    bit                m_mode;
    logic [DATA_W-1:0] m_frame[$];
    int                m_cnt;

    par_frame_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    par_frame_checker #(
        .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: holds the open frame as a list of beats, decides at eop
    task automatic model_step(input bit v, s, e, input logic [DATA_W-1:0] d,
                              input bit p, m, c);
        bit ev_res = 0, ok = 0, ferr = 0;
        int ones;
        exp_t rec;
        if (v) begin
            if (s) begin
                ferr = m_open;
                m_frame.delete();
                m_frame.push_back(d);
                m_mode = m;
                m_open = 1;
            end else if (m_open) begin
                m_frame.push_back(d);
            end else begin
                ferr = 1;
            end
            if (m_open) begin
                if (e) begin
                    ones = int'(p);
                    foreach (m_frame[i]) ones += $countones(m_frame[i]);
                    ev_res = 1;
                    ok = ((ones % 2) == int'(m_mode));
                    m_open = 0;
                end else if (m_frame.size() == MAX_BEATS) begin
                    ferr = 1;
                    m_open = 0;
                end
            end
        end
        if (c) m_cnt = 0;
        else if ((ferr || (ev_res && !ok)) && m_cnt < CNT_MAX) m_cnt++;
        if (ev_res || ferr) begin
            rec.rv = ev_res; rec.ok = ok; rec.fe = ferr; rec.cnt = CNT_W'(m_cnt);
            exp_q.push_back(rec);
        end
    endtask

    task automatic drive(input bit v, s, e, input logic [DATA_W-1:0] d,
                         input bit p, m, c);
        @(posedge clk); #1;
        bus.in_valid = v; bus.in_sop = s; bus.in_eop = e; bus.in_data = d;
        bus.in_par = p; bus.mode = m; bus.clr_cnt = c;
        model_step(v, s, e, d, p, m, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic cnt_check(input string name);
        idle(1);
        @(posedge clk); #2;
        chk(name, 32'(bus.err_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.clr_cnt = 1'b0;
        m_open = 0; m_frame.delete(); m_cnt = 0;
        @(posedge clk); #2;
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_parity_ok", 32'(bus.parity_ok), 0);
        chk("rst_frame_err", 32'(bus.frame_err), 0);
        chk("rst_err_cnt",   32'(bus.err_cnt),   0);
        rst = 1'b1;
    endtask

    // Monitor: every output event pops one expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.res_valid === 1'b1 || bus.frame_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event actual rv=%0b fe=%0b required none t=%0t",
                             bus.res_valid, bus.frame_err, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_valid", 32'(bus.res_valid), 32'(e.rv));
                    chk("parity_ok", 32'(bus.parity_ok), 32'(e.ok));
                    chk("frame_err", 32'(bus.frame_err), 32'(e.fe));
                    chk("err_cnt",   32'(bus.err_cnt),   32'(e.cnt));
                end
            end else begin
                chk("parity_ok_idle", 32'(bus.parity_ok), 0);
            end
        end
    end

    initial begin
        bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_data = '0;
        bus.in_par = 0; bus.mode = 0; bus.clr_cnt = 0;
        m_open = 0; m_mode = 0; m_cnt = 0;
        do_reset();
        mon_en = 1'b1;

        // Single-beat frame, even mode: 0x07 + par 1 is even
        drive(1, 1, 1, 8'h07, 1, 0, 0);
        cnt_check("single_cnt");

        // Three-beat frame with a gap, odd then even mode
        drive(1, 1, 0, 8'h01, 0, 1, 0);
        drive(0, 0, 0, 8'h00, 0, 0, 0);
        drive(1, 0, 0, 8'h03, 0, 0, 0);
        drive(1, 0, 1, 8'h00, 0, 0, 0);
        drive(1, 1, 0, 8'h01, 0, 0, 0);
        drive(0, 0, 0, 8'h00, 0, 1, 0);
        drive(1, 0, 0, 8'h03, 0, 1, 0);
        drive(1, 0, 1, 8'h00, 0, 1, 0);
        cnt_check("three_beat_cnt");

        // Beat without sop in IDLE, then sop inside an open frame
        drive(1, 0, 0, 8'h55, 0, 0, 0);
        drive(1, 1, 0, 8'h01, 0, 0, 0);
        drive(1, 1, 0, 8'h02, 0, 0, 0);
        drive(1, 0, 1, 8'h04, 0, 0, 0);
        cnt_check("framing_cnt");

        // Overlength: four non-eop beats, then a stray fifth
        do_reset();
        drive(1, 1, 0, 8'h11, 0, 0, 0);
        drive(1, 0, 0, 8'h22, 0, 0, 0);
        drive(1, 0, 0, 8'h33, 0, 0, 0);
        drive(1, 0, 0, 8'h44, 0, 0, 0);
        drive(1, 0, 0, 8'h55, 0, 0, 0);
        cnt_check("overlength_cnt");

        // Saturation at 3, then clear wins over a simultaneous failure
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 8'h01, 0, 0, 0);
        drive(1, 1, 1, 8'h01, 0, 0, 1);
        cnt_check("clr_cnt");

        // Reset mid-frame discards the frame silently
        drive(1, 1, 0, 8'h0f, 0, 0, 0);
        drive(1, 0, 0, 8'hf0, 0, 0, 0);
        do_reset();
        drive(1, 0, 1, 8'h01, 0, 0, 0);
        cnt_check("post_reset_cnt");

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 3), DATA_W'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
        end
        cnt_check("random_cnt");

        idle(3);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
